newton_step: RTL and testbench

//  Newton/Broyden x-update stage: next_x = x - invJ * f. It sits directly upstream of next_invJ and produces the next_x it consumes.

---
 rtl/newton_pkg.sv | 28 ++
 rtl/fp_mac.sv | 143 ++++++++++++++
 rtl/newton_step.sv | 173 +++++++++++++++++
 tb/tb_newton_step.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/newton_pkg.sv
// Shared widths, FSM encodings, FP constants and the invJ index helper
// for the newton_step x-update stage.
package newton_pkg;

  localparam int FP_W = 32;
  localparam int N_X  = 3;
  localparam int N_F  = 4;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_ACC  = 3'd2;
  localparam logic [2:0] S_SUB  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] OP_MUL = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_SUB = 2'd2;

  localparam logic [FP_W-1:0] ZERO = 32'h0000_0000;
  localparam logic [FP_W-1:0] ONE  = 32'h3F80_0000;
  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  function automatic logic [3:0] inv_idx(input logic [1:0] r,
                                         input logic [1:0] c);
    return {r, 2'b00} + {2'b00, c};
  endfunction

endpackage

// File: rtl/fp_mac.sv
// One FP32 multiplier plus one FP32 adder behind a single start/done port.
// Round-to-nearest-even; denormal inputs and outputs flush to zero.
module fp_mac
  import newton_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_done,
  output logic [31:0] o_res
);

  function automatic logic [31:0] fp_mul(input logic [31:0] a,
                                         input logic [31:0] b);
    logic               s;
    logic [47:0]        p;
    logic signed [9:0]  e;
    logic [24:0]        m;
    logic               g;
    logic               st;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) ||
          (b[30:23] == 8'hFF && b[22:0] != 23'h0) ||
          a[30:23] == 8'h00 || b[30:23] == 8'h00)
        return QNAN;
      return {s, 8'hFF, 23'h0};
    end
    if (a[30:23] == 8'h00 || b[30:23] == 8'h00) return {s, 31'h0};
    p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    if (p[47]) begin
      m  = {1'b0, p[47:24]};
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = {1'b0, p[46:23]};
      g  = p[22];
      st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
    if (e <= 10'sd0) return {s, 31'h0};
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0]        u;
    logic [31:0]        v;
    logic [26:0]        mu;
    logic [26:0]        mv;
    logic [7:0]         d;
    logic [27:0]        sum;
    logic signed [9:0]  e;
    logic [24:0]        m;
    logic               st;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if ((a[30:23] == 8'hFF && a[22:0] != 23'h0) ||
          (b[30:23] == 8'hFF && b[22:0] != 23'h0) ||
          (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]))
        return QNAN;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:23] == 8'h00 && b[30:23] == 8'h00) return {a[31] & b[31], 31'h0};
    if (a[30:23] == 8'h00) return b;
    if (b[30:23] == 8'h00) return a;
    if (a[30:0] >= b[30:0]) begin
      u = a;
      v = b;
    end else begin
      u = b;
      v = a;
    end
    mu = {1'b1, u[22:0], 3'b000};
    mv = {1'b1, v[22:0], 3'b000};
    d  = u[30:23] - v[30:23];
    st = 1'b0;
    for (int i = 0; i < 27; i++)
      if (i < int'(d)) st = st | mv[i];
    mv    = (d > 8'd26) ? 27'h0 : (mv >> d);
    mv[0] = mv[0] | st;
    e = $signed({2'b00, u[30:23]});
    if (u[31] == v[31]) begin
      sum = {1'b0, mu} + {1'b0, mv};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 10'sd1;
      end
    end else begin
      sum = {1'b0, mu} - {1'b0, mv};
      if (sum == 28'h0) return ZERO;
      for (int i = 0; i < 26; i++)
        if (!sum[26]) begin
          sum = sum << 1;
          e   = e - 10'sd1;
        end
    end
    m = {1'b0, sum[26:3]};
    if (sum[2] && (sum[1] || sum[0] || m[0])) m = m + 25'd1;
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'sd1;
    end
    if (e >= 10'sd255) return {u[31], 8'hFF, 23'h0};
    if (e <= 10'sd0) return {u[31], 31'h0};
    return {u[31], e[7:0], m[22:0]};
  endfunction

  logic        r_mul_stb;
  logic        r_add_stb;
  logic [31:0] r_mul_res;
  logic [31:0] r_add_res;
  logic [31:0] w_b_eff;

  assign w_b_eff = (i_op == OP_SUB) ? {~i_b[31], i_b[30:0]} : i_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mul_stb <= 1'b0;
      r_add_stb <= 1'b0;
      r_mul_res <= ZERO;
      r_add_res <= ZERO;
    end else begin
      r_mul_stb <= i_start && (i_op == OP_MUL);
      r_add_stb <= i_start && (i_op != OP_MUL);
      if (i_start && i_op == OP_MUL) r_mul_res <= fp_mul(i_a, i_b);
      if (i_start && i_op != OP_MUL) r_add_res <= fp_add(i_a, w_b_eff);
    end
  end

  assign o_done = r_mul_stb | r_add_stb;
  assign o_res  = r_mul_stb ? r_mul_res : r_add_res;

endmodule

// File: rtl/newton_step.sv
// Newton/Broyden x-update: next_x = x - invJ*f on one shared fp_mac.
// Define NEWTON_CONV_EN to add TOL_EXP and the converged output.
module newton_step
  import newton_pkg::*;
`ifdef NEWTON_CONV_EN
#(
  parameter logic [7:0] TOL_EXP = 8'd100
)
`endif
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [383:0] invJ,
  input  logic [127:0] f,
  input  logic [95:0]  x,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef NEWTON_CONV_EN
  output logic         converged,
`endif
  output logic [95:0]  next_x
);

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_in_ready;
  logic [11:0][31:0] r_invj;
  logic [3:0][31:0]  r_f;
  logic [2:0][31:0]  r_x;
  logic [2:0][31:0]  r_next_x;
  logic [31:0]       r_acc;
  logic [31:0]       r_prod;
  logic [1:0]        r_row;
  logic [1:0]        r_col;
  logic              r_pend;
  logic              w_start;
  logic [1:0]        w_op;
  logic [31:0]       w_a;
  logic [31:0]       w_b;
  logic              w_done;
  logic [31:0]       w_res;
  logic              w_cap;

  assign w_cap = (r_state == S_IDLE) && in_valid && r_in_ready;

  fp_mac u_mac (
    .clk     (clk),
    .rst_n   (rst),
    .i_start (w_start),
    .i_op    (w_op),
    .i_a     (w_a),
    .i_b     (w_b),
    .o_done  (w_done),
    .o_res   (w_res)
  );

  // in_ready is registered so it stays low while rst is asserted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == S_IDLE);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (1'b1)
      (r_state == S_IDLE): if (w_cap) w_next = S_MUL;
      (r_state == S_MUL):  if (w_done) w_next = S_ACC;
      (r_state == S_ACC): begin
        if (r_col == 2'd0) w_next = S_MUL;
        else if (w_done) w_next = (r_col == 2'd3) ? S_SUB : S_MUL;
      end
      (r_state == S_SUB):
        if (w_done) w_next = (r_row == 2'd2) ? S_DONE : S_MUL;
      (r_state == S_DONE): if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_start = 1'b0;
    w_op    = OP_MUL;
    w_a     = ZERO;
    w_b     = ZERO;
    unique case (1'b1)
      (r_state == S_MUL): begin
        w_start = !r_pend;
        w_a     = r_invj[inv_idx(r_row, r_col)];
        w_b     = r_f[r_col];
      end
      (r_state == S_ACC): begin
        w_start = !r_pend && (r_col != 2'd0);
        w_op    = OP_ADD;
        w_a     = r_acc;
        w_b     = r_prod;
      end
      (r_state == S_SUB): begin
        w_start = !r_pend;
        w_op    = OP_SUB;
        w_a     = r_x[r_row];
        w_b     = r_acc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_invj   <= '0;
      r_f      <= '0;
      r_x      <= '0;
      r_next_x <= '0;
      r_acc    <= ZERO;
      r_prod   <= ZERO;
      r_row    <= 2'd0;
      r_col    <= 2'd0;
      r_pend   <= 1'b0;
    end else begin
      if (w_start) r_pend <= 1'b1;
      else if (w_done) r_pend <= 1'b0;
      unique case (1'b1)
        (r_state == S_IDLE): if (w_cap) begin
          r_invj <= invJ;
          r_f    <= f;
          r_x    <= x;
          r_row  <= 2'd0;
          r_col  <= 2'd0;
        end
        (r_state == S_MUL): if (w_done) r_prod <= w_res;
        // first column loads directly so a -0 product survives
        (r_state == S_ACC): begin
          if (r_col == 2'd0) begin
            r_acc <= r_prod;
            r_col <= 2'd1;
          end else if (w_done) begin
            r_acc <= w_res;
            r_col <= r_col + 2'd1;
          end
        end
        (r_state == S_SUB): if (w_done) begin
          r_next_x[r_row] <= w_res;
          if (r_row != 2'd2) r_row <= r_row + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef NEWTON_CONV_EN
  logic r_conv_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_conv_ok <= 1'b0;
    else if (w_cap) r_conv_ok <= 1'b1;
    else if (r_state == S_ACC && r_col == 2'd3 && w_done &&
             w_res[30:23] >= TOL_EXP)
      r_conv_ok <= 1'b0;
  end

  assign converged = (r_state == S_DONE) && r_conv_ok;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == S_DONE);
  assign next_x    = r_next_x;

endmodule

// File: tb/tb_newton_step.sv
// Directed bench for newton_step: identity/negative bundles, backpressure,
// mid-run reset, busy-time in_valid and (with NEWTON_CONV_EN) convergence.
module tb_newton_step;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [383:0] invJ = '0;
  logic [127:0] f = '0;
  logic [95:0]  x = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [95:0]  next_x;
`ifdef NEWTON_CONV_EN
  logic         converged;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] F1   = 32'h3F80_0000;
  localparam logic [31:0] F2   = 32'h4000_0000;
  localparam logic [31:0] F3   = 32'h4040_0000;
  localparam logic [31:0] F10  = 32'h4120_0000;
  localparam logic [31:0] FM05 = 32'hBF00_0000;
  localparam logic [95:0] EXP1 = {32'h40E0_0000, 32'h4100_0000, 32'h4110_0000};

  newton_step dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .invJ      (invJ),
    .f         (f),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef NEWTON_CONV_EN
    .converged (converged),
`endif
    .next_x    (next_x)
  );

  always #5 clk = ~clk;

  function automatic logic [383:0] ident_j();
    logic [383:0] v;
    v = '0;
    for (int r = 0; r < 3; r++) v[32*(5*r) +: 32] = F1;
    return v;
  endfunction

  task automatic send(input logic [383:0] j, input logic [127:0] ff,
                      input logic [95:0] xx);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    invJ = j;
    f = ff;
    x = xx;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || next_x !== 96'h0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b next_x=%h required 0 0 0",
               in_ready, out_valid, next_x);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_identity();
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    wait_out("identity");
    checks++;
    if (next_x !== EXP1) begin
      errors++;
      $display("FAIL identity_x: got %h required %h", next_x, EXP1);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL identity_busy: in_ready=%b required 0", in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL identity_handoff: out_valid=%b in_ready=%b required 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    wait_out("backpressure");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || next_x !== EXP1) begin
        errors++;
        $display("FAIL hold_%0d: out_valid=%b in_ready=%b next_x=%h required 1 0 %h",
                 i, out_valid, in_ready, next_x, EXP1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b required 1 0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_neg_accum();
    send({12{F1}}, {4{FM05}}, 96'h0);
    wait_out("neg_accum");
    checks++;
    if (next_x !== {3{F2}}) begin
      errors++;
      $display("FAIL neg_accum_x: got %h required %h", next_x, {3{F2}});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midop_early: out_valid=%b required 0", out_valid);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || next_x !== 96'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midop_abort: out_valid=%b next_x=%h in_ready=%b required 0 0 0",
               out_valid, next_x, in_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midop_spurious_%0d: out_valid=%b required 0", i, out_valid);
      end
    end
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    wait_out("midop_rerun");
    checks++;
    if (next_x !== EXP1) begin
      errors++;
      $display("FAIL midop_rerun_x: got %h required %h", next_x, EXP1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_busy_ignore();
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready: in_ready=%b required 0", in_ready);
    end
    x = {F1, F1, F1};
    f = {4{FM05}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("busy");
    checks++;
    if (next_x !== EXP1) begin
      errors++;
      $display("FAIL busy_x: got %h required %h", next_x, EXP1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

`ifdef NEWTON_CONV_EN
  task automatic test_conv();
    send(ident_j(), {96'h0, 32'h0DA2_4260}, {F10, F10, F10});
    wait_out("conv_small");
    checks++;
    if (converged !== 1'b1 || next_x !== {F10, F10, F10}) begin
      errors++;
      $display("FAIL conv_small: converged=%b next_x=%h required 1 %h",
               converged, next_x, {F10, F10, F10});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (converged !== 1'b0) begin
      errors++;
      $display("FAIL conv_clear: converged=%b required 0", converged);
    end
    send(ident_j(), {32'h0, F3, F2, F1}, {F10, F10, F10});
    wait_out("conv_large");
    checks++;
    if (converged !== 1'b0) begin
      errors++;
      $display("FAIL conv_large: converged=%b required 0", converged);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_identity();
    test_backpressure();
    test_neg_accum();
    test_reset_midop();
    test_busy_ignore();
`ifdef NEWTON_CONV_EN
    test_conv();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
